// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Purpose:
//   Shared instruction/data memory port between the multicycle control unit
//   and the memory. The port uses a req/ack handshake: the requester holds
//   mem_req, mem_we and mem_data_sel steady until the cycle in which the
//   memory raises mem_ack.
//
// Signals:
//   mem_req       control -> memory   request active
//   mem_we        control -> memory   write strobe, meaningful with mem_req
//   mem_data_sel  control -> memory   0 = instruction address, 1 = data address
//   mem_ack       memory  -> control  request completes this cycle
//
// Modports:
//   master  the control unit (drives the request)
//   slave   the memory (drives the acknowledge)
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_data_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_data_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_data_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose:
//   Multicycle control unit for the 16-bit core. Each instruction walks
//   through FETCH, DECODE, EXEC, MEM and WB over one shared memory port.
//   The decoded control word is captured once per instruction at the end of
//   DECODE, a watchdog faults the unit if memory never answers, and a
//   retired-instruction counter plus a sticky fault flag are exposed.
//
// Parameters:
//   OPCODE_W     opcode width (>= 5); bits above [4:0] must be zero
//   MEM_TIMEOUT  wait cycles allowed before faulting, 0 disables the watchdog
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   m_mem                 memory port (master side of the req/ack handshake)
//   i_ir_opcode           opcode field of the instruction register
//   i_br_cond             datapath branch condition, used in EXEC
//   o_ir_write            load the instruction register
//   o_pc_write, o_pc_src  PC update strobe and source (0 PC+2, 1 branch, 2 jump)
//   o_reg_write           register-file write enable
//   o_reg_zero            write zero to the destination register
//   o_mem_to_reg          select load data for write-back
//   o_alu_src, o_alu_op, o_alu_b, o_unsig, o_bh, o_imm_op   latched control word
//   o_retire_cnt          retired-instruction count (wraps)
//   o_retired             one-cycle pulse when an instruction retires
//   o_fault               sticky fault flag
//   o_state               current state (0 FETCH .. 4 WB, 7 FAULT)
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  multicycle_control_unit_if.master m_mem,
  input  logic [OPCODE_W-1:0]  i_ir_opcode,
  input  logic                 i_br_cond,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic [1:0]           o_pc_src,
  output logic                 o_reg_write,
  output logic                 o_reg_zero,
  output logic                 o_mem_to_reg,
  output logic                 o_alu_src,
  output logic [1:0]           o_alu_op,
  output logic [1:0]           o_alu_b,
  output logic                 o_unsig,
  output logic                 o_bh,
  output logic [3:0]           o_imm_op,
  output logic [CNT_W-1:0]     o_retire_cnt,
  output logic                 o_retired,
  output logic                 o_fault,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  // isJump covers both JUMP and JAL: they sequence identically.
  typedef struct packed {
    logic       aluSrc;
    logic       bh;
    logic       unsig;
    logic [1:0] aluB;
    logic [1:0] aluOp;
    logic [3:0] immOp;
    logic       isLoad;
    logic       isStore;
    logic       isBranch;
    logic       isJump;
    logic       isRst;
  } ctrl_t;

  // The counter must be able to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  ctrl_t             r_ctrl;
  ctrl_t             w_dec;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_retireCnt;

  logic [4:0] w_op;
  logic       w_upperBad;
  logic       w_isJal, w_isRst, w_isDimm, w_isLoad, w_isJump;
  logic       w_isAlui, w_isBranch, w_isStore, w_jrd;
  logic       w_timeout;
  logic       w_memReq, w_memWe, w_memDataSel;
  logic       w_retire;

  assign w_op = i_ir_opcode[4:0];

  // Opcode bits above the class field are reserved and must read as zero.
  generate
    if (OPCODE_W > 5) begin : g_upper
      assign w_upperBad = |i_ir_opcode[OPCODE_W-1:5];
    end else begin : g_noUpper
      assign w_upperBad = 1'b0;
    end
  endgenerate

  assign w_isJal    = (w_op == 5'b00000);
  assign w_isRst    = (w_op == 5'b00001);
  assign w_isDimm   = (w_op[4:1] == 4'b0001);
  assign w_isLoad   = (w_op[4:2] == 3'b001);
  assign w_isJump   = (w_op[4:2] == 3'b010);
  assign w_isAlui   = (w_op[4:2] == 3'b011);
  assign w_isBranch = (w_op[4:3] == 2'b10);
  assign w_isStore  = (w_op[4:2] == 3'b110);
  assign w_jrd      = w_isJal | w_isRst | w_isDimm;

  // Control word for the instruction currently in the IR; it only becomes
  // visible once captured at the end of DECODE.
  always_comb begin
    w_dec          = '0;
    w_dec.aluSrc   = w_isAlui | w_isLoad | w_isStore;
    w_dec.bh       = w_op[1];
    w_dec.unsig    = w_op[0];
    w_dec.aluB     = {w_op[2], w_op[1]};
    w_dec.aluOp[0] = w_isLoad | w_isStore | (w_op == 5'b11111) | (w_op == 5'b01111);
    w_dec.aluOp[1] = w_isBranch | (w_op == 5'b11111);
    w_dec.immOp    = {w_jrd & w_op[0], w_isJal | w_isJump | w_isBranch, w_jrd,
                      w_isAlui | w_isLoad};
    w_dec.isLoad   = w_isLoad;
    w_dec.isStore  = w_isStore;
    w_dec.isBranch = w_isBranch;
    w_dec.isJump   = w_isJump | w_isJal;
    w_dec.isRst    = w_isRst;
  end

  // A disabled watchdog (MEM_TIMEOUT = 0) never fires.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_waitCnt == TIMEOUT_V);

  // Next-state and strobe logic. An ack landing in the same cycle the
  // watchdog expires is checked first, so the access completes normally.
  // Reset forces every strobe low so an abandoned access cannot write.
  always_comb begin
    w_next       = r_state;
    w_memReq     = 1'b0;
    w_memWe      = 1'b0;
    w_memDataSel = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'd0;
    o_reg_write  = 1'b0;
    o_reg_zero   = 1'b0;
    o_mem_to_reg = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq = 1'b1;
        if (m_mem.mem_ack) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_next = w_upperBad ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        if (r_ctrl.isBranch) begin
          o_pc_write = i_br_cond;
          o_pc_src   = 2'd1;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (r_ctrl.isJump) begin
          o_pc_write = 1'b1;
          o_pc_src   = 2'd2;
          w_next     = S_WB;
        end else if (r_ctrl.isLoad || r_ctrl.isStore) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_memReq     = 1'b1;
        w_memDataSel = 1'b1;
        w_memWe      = r_ctrl.isStore;
        if (m_mem.mem_ack) begin
          if (r_ctrl.isStore) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = r_ctrl.isLoad;
        o_reg_zero   = r_ctrl.isRst;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_FAULT;
      end
    endcase
    if (i_rst) begin
      w_memReq     = 1'b0;
      w_memWe      = 1'b0;
      w_memDataSel = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'd0;
      o_reg_write  = 1'b0;
      o_reg_zero   = 1'b0;
      o_mem_to_reg = 1'b0;
      w_retire     = 1'b0;
      w_next       = S_FETCH;
    end
  end

  // State, control word, watchdog and retire counter. The wait counter
  // restarts on every state change and on each completed access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_ctrl      <= '0;
      r_waitCnt   <= '0;
      r_retireCnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_ctrl <= w_dec;
      end
      if ((w_next != r_state) || (w_memReq && m_mem.mem_ack)) begin
        r_waitCnt <= '0;
      end else if (w_memReq) begin
        r_waitCnt <= r_waitCnt + WAIT_W'(1);
      end
      if (w_retire) begin
        r_retireCnt <= r_retireCnt + CNT_W'(1);
      end
    end
  end

  assign m_mem.mem_req      = w_memReq;
  assign m_mem.mem_we       = w_memWe;
  assign m_mem.mem_data_sel = w_memDataSel;

  assign o_alu_src    = r_ctrl.aluSrc;
  assign o_alu_op     = r_ctrl.aluOp;
  assign o_alu_b      = r_ctrl.aluB;
  assign o_unsig      = r_ctrl.unsig;
  assign o_bh         = r_ctrl.bh;
  assign o_imm_op     = r_ctrl.immOp;
  assign o_retire_cnt = r_retireCnt;
  assign o_retired    = w_retire;
  assign o_fault      = (r_state == S_FAULT);
  assign o_state      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for the multicycle control unit. dut0 uses a 6-bit opcode
// so the reserved upper bit can be exercised; dut1 uses a 2-bit retire
// counter to show wrap-around. Inputs change 1 time unit after the rising
// edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // dut0: OPCODE_W = 6, default timeout and counter width
  logic        rst0 = 1'b1;
  logic [5:0]  op0  = '0;
  logic        ack0 = 1'b0;
  logic        brc0 = 1'b0;
  logic        irWrite0, pcWrite0, regWrite0, regZero0, memToReg0;
  logic        aluSrc0, unsig0, bh0, retired0, fault0;
  logic [1:0]  pcSrc0, aluOp0, aluB0;
  logic [3:0]  immOp0;
  logic [15:0] retireCnt0;
  logic [2:0]  state0;

  multicycle_control_unit_if bus0 ();
  assign bus0.mem_ack = ack0;

  multicycle_control_unit #(.OPCODE_W(6), .MEM_TIMEOUT(16), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst(rst0), .m_mem(bus0), .i_ir_opcode(op0), .i_br_cond(brc0),
    .o_ir_write(irWrite0), .o_pc_write(pcWrite0), .o_pc_src(pcSrc0),
    .o_reg_write(regWrite0), .o_reg_zero(regZero0), .o_mem_to_reg(memToReg0),
    .o_alu_src(aluSrc0), .o_alu_op(aluOp0), .o_alu_b(aluB0), .o_unsig(unsig0),
    .o_bh(bh0), .o_imm_op(immOp0), .o_retire_cnt(retireCnt0), .o_retired(retired0),
    .o_fault(fault0), .o_state(state0)
  );

  // dut1: OPCODE_W = 5, 2-bit retire counter
  logic        rst1 = 1'b1;
  logic [4:0]  op1  = 5'b01111;
  logic        ack1 = 1'b1;
  logic        brc1 = 1'b0;
  logic        irWrite1, pcWrite1, regWrite1, regZero1, memToReg1;
  logic        aluSrc1, unsig1, bh1, retired1, fault1;
  logic [1:0]  pcSrc1, aluOp1, aluB1;
  logic [3:0]  immOp1;
  logic [1:0]  retireCnt1;
  logic [2:0]  state1;

  multicycle_control_unit_if bus1 ();
  assign bus1.mem_ack = ack1;

  multicycle_control_unit #(.OPCODE_W(5), .MEM_TIMEOUT(16), .CNT_W(2)) dut1 (
    .i_clk(clk), .i_rst(rst1), .m_mem(bus1), .i_ir_opcode(op1), .i_br_cond(brc1),
    .o_ir_write(irWrite1), .o_pc_write(pcWrite1), .o_pc_src(pcSrc1),
    .o_reg_write(regWrite1), .o_reg_zero(regZero1), .o_mem_to_reg(memToReg1),
    .o_alu_src(aluSrc1), .o_alu_op(aluOp1), .o_alu_b(aluB1), .o_unsig(unsig1),
    .o_bh(bh1), .o_imm_op(immOp1), .o_retire_cnt(retireCnt1), .o_retired(retired1),
    .o_fault(fault1), .o_state(state1)
  );

  // Per-instruction observations gathered by runInstr
  int          latency;
  logic [29:0] trace;
  int          regWriteCycles;
  int          memCycles;
  int          weCycles;
  int          overlapCycles;
  logic        execPcWrite;
  logic [1:0]  execPcSrc;
  logic        wbMemToReg;
  logic        wbRegZero;
  logic        faulted;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic ack, input logic brc);
    op0  = op;
    ack0 = ack;
    brc0 = brc;
  endtask

  task automatic resetDut0();
    applyStimulus(6'b000000, 1'b0, 1'b0);
    rst0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    #1;
  endtask

  // Runs one instruction from FETCH with the fetch acked immediately and the
  // data access acked after dataDelay wait cycles (negative = never). Stops
  // on retire or fault, bounded at 40 cycles.
  task automatic runInstr(input logic [5:0] op, input logic brc, input int dataDelay);
    int memWait;
    bit done;
    memWait = 0;
    done = 1'b0;
    latency = 0; trace = '0; regWriteCycles = 0; memCycles = 0; weCycles = 0;
    overlapCycles = 0; execPcWrite = 1'b0; execPcSrc = 2'd0;
    wbMemToReg = 1'b0; wbRegZero = 1'b0; faulted = 1'b0;
    applyStimulus(op, 1'b0, brc);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == 0 && state0 == 3'd0) ack0 = 1'b1;
      else if (state0 == 3'd3) ack0 = (dataDelay >= 0) && (memWait == dataDelay);
      else ack0 = 1'b0;
      @(negedge clk);
      latency++;
      trace = {trace[26:0], state0};
      if (regWrite0) regWriteCycles++;
      if (state0 == 3'd3 && bus0.mem_req && bus0.mem_data_sel) memCycles++;
      if (bus0.mem_we) weCycles++;
      if (bus0.mem_we && regWrite0) overlapCycles++;
      if (state0 == 3'd2) begin
        execPcWrite = pcWrite0;
        execPcSrc   = pcSrc0;
      end
      if (state0 == 3'd4) begin
        wbMemToReg = memToReg0;
        wbRegZero  = regZero0;
      end
      if (retired0) done = 1'b1;
      if (fault0) begin
        faulted = 1'b1;
        done = 1'b1;
      end
      if (state0 == 3'd3) memWait++;
      @(posedge clk); #1;
    end
    ack0 = 1'b0;
  endtask

  initial begin
    int expSeq[5];
    int k;
    int pulses;
    bit checkNext;

    $display("[TB] start");

    // Reset state, then FETCH request
    resetDut0();
    checkOutput("rstState", state0, 3'd0);
    checkOutput("rstRetireCnt", retireCnt0, 16'd0);
    checkOutput("rstFault", fault0, 1'b0);
    checkOutput("rstImmOp", immOp0, 4'd0);
    checkOutput("fetchReq", {bus0.mem_req, bus0.mem_we, bus0.mem_data_sel}, 3'b100);

    // ALUR 11111
    runInstr(6'b011111, 1'b0, 0);
    checkOutput("alurLatency", latency, 4);
    checkOutput("alurTrace", trace, {3'd0, 3'd1, 3'd2, 3'd4});
    checkOutput("alurRegWrites", regWriteCycles, 1);
    checkOutput("alurAluOp", aluOp0, 2'b11);
    checkOutput("alurAluSrc", aluSrc0, 1'b0);
    checkOutput("alurRetireCnt", retireCnt0, 16'd1);
    checkOutput("alurBackToFetch", state0, 3'd0);

    // LOAD 00110 with data ack after 3 wait cycles
    runInstr(6'b000110, 1'b0, 3);
    checkOutput("loadLatency", latency, 8);
    checkOutput("loadTrace", trace, {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4});
    checkOutput("loadMemCycles", memCycles, 4);
    checkOutput("loadMemToReg", wbMemToReg, 1'b1);
    checkOutput("loadBh", bh0, 1'b1);
    checkOutput("loadImmOp", immOp0, 4'b0001);
    checkOutput("loadNoWe", weCycles, 0);
    checkOutput("loadRetireCnt", retireCnt0, 16'd2);

    // BRANCH 10000, taken then not taken
    runInstr(6'b010000, 1'b1, 0);
    checkOutput("brTakenLatency", latency, 3);
    checkOutput("brTakenPcWrite", execPcWrite, 1'b1);
    checkOutput("brTakenPcSrc", execPcSrc, 2'd1);
    checkOutput("brImmOp", immOp0, 4'b0100);
    checkOutput("brAluOp", aluOp0, 2'b10);
    runInstr(6'b010000, 1'b0, 0);
    checkOutput("brNotTakenLatency", latency, 3);
    checkOutput("brNotTakenPcWrite", execPcWrite, 1'b0);
    checkOutput("brRetireCnt", retireCnt0, 16'd4);

    // RST 00001 through a 6-bit opcode with the upper bit clear
    runInstr(6'b000001, 1'b0, 0);
    checkOutput("rstOpLatency", latency, 4);
    checkOutput("rstOpRegZero", wbRegZero, 1'b1);
    checkOutput("rstOpImmOp", immOp0, 4'b1010);
    checkOutput("rstOpRetireCnt", retireCnt0, 16'd5);

    // STORE whose ack lands exactly as the watchdog expires: completes
    runInstr(6'b011000, 1'b0, 16);
    checkOutput("stEdgeLatency", latency, 20);
    checkOutput("stEdgeFault", faulted, 1'b0);
    checkOutput("stEdgeWeCycles", weCycles, 17);
    checkOutput("stEdgeOverlap", overlapCycles, 0);
    checkOutput("stEdgeRetireCnt", retireCnt0, 16'd6);

    // STORE that is never acked: 17 MEM cycles, then FAULT
    runInstr(6'b011000, 1'b0, -1);
    checkOutput("stToFaulted", faulted, 1'b1);
    checkOutput("stToLatency", latency, 21);
    checkOutput("stToMemCycles", memCycles, 17);
    ack0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("faultState", state0, 3'd7);
      checkOutput("faultStrobes",
                  {bus0.mem_req, bus0.mem_we, irWrite0, pcWrite0, regWrite0, retired0},
                  6'b000000);
      checkOutput("faultFrozenCnt", retireCnt0, 16'd6);
      checkOutput("faultFlag", fault0, 1'b1);
      @(posedge clk); #1;
    end
    resetDut0();
    checkOutput("postFaultState", state0, 3'd0);
    checkOutput("postFaultCnt", retireCnt0, 16'd0);
    checkOutput("postFaultFlag", fault0, 1'b0);

    // Reserved upper opcode bit set: DECODE goes straight to FAULT
    runInstr(6'b100001, 1'b0, 0);
    checkOutput("upperLatency", latency, 3);
    checkOutput("upperTrace", trace, {3'd0, 3'd1, 3'd7});
    checkOutput("upperFault", faulted, 1'b1);
    checkOutput("upperNoRegWrite", regWriteCycles, 0);
    resetDut0();

    // Reset in the middle of a store access drops the write strobe
    applyStimulus(6'b011000, 1'b1, 1'b0);
    @(posedge clk); #1;
    ack0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midStoreState", state0, 3'd3);
    checkOutput("midStoreWe", bus0.mem_we, 1'b1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    #1;
    checkOutput("abandonState", state0, 3'd0);
    checkOutput("abandonWe", bus0.mem_we, 1'b0);
    checkOutput("abandonReq", bus0.mem_req, 1'b1);

    // dut1: five ALUI 01111 instructions with a 2-bit retire counter
    expSeq = '{1, 2, 3, 0, 1};
    k = 0;
    pulses = 0;
    checkNext = 1'b0;
    rst1 = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (checkNext && k < 5) begin
        checkOutput("wrapCnt", retireCnt1, expSeq[k]);
        k++;
        checkNext = 1'b0;
      end
      if (retired1) begin
        pulses++;
        checkNext = 1'b1;
      end
    end
    checkOutput("wrapPulses", pulses, 5);
    checkOutput("wrapChecks", k, 5);
    checkOutput("aluiAluSrc", aluSrc1, 1'b1);
    checkOutput("aluiAluOp", aluOp1, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multicycle successor to the single-cycle opcode decoder for the 16-bit core.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states over a shared instruction/data memory port with a req/ack handshake.
- Latches the decoded control word once per instruction and enforces a memory-timeout watchdog.
- Exposes a retired-instruction counter and a sticky fault flag.

Parameters:
- OPCODE_W, 5: opcode field width. Must be >= 5. Class is decoded from bits [4:0]; bits [OPCODE_W-1:5] must be zero.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ack before FAULT. A value of 0 disables the watchdog.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- ir_opcode  in  OPCODE_W  opcode field of the instruction register (valid from DECODE onward)
- mem_ack  in  1  memory completes the current request this cycle
- br_cond  in  1  datapath branch condition, sampled in EXEC
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_data_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result)
- ir_write  out  1  load the instruction register
- pc_write  out  1  update the PC
- pc_src  out  2  PC source: 0 = PC+2, 1 = branch target, 2 = jump target
- reg_write  out  1  register-file write enable
- reg_zero  out  1  write zero to the destination register
- mem_to_reg  out  1  select load data for write-back
- alu_src  out  1  select immediate as ALU B operand
- alu_op  out  2  ALU operation class
- alu_b  out  2  {btype, binv}
- unsig  out  1  unsigned compare/extend
- bh  out  1  byte/half select for memory access
- imm_op  out  4  {sll7, sll1, imm7/9, imm7type}
- retire_cnt  out  CNT_W  count of retired instructions
- retired  out  1  one-cycle pulse when an instruction retires
- fault  out  1  sticky fault flag
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 FAULT

Behaviour:
- Reset:
  - state = FETCH.
  - retire_cnt, the wait counter and the control-word register = 0.
  - fault = 0.
  - All strobes = 0.
  - Reset mid-request abandons the access with no write strobe on the following cycle.
- Opcode classes, decoded from op = ir_opcode[4:0]:
  - JAL: 00000
  - RST: 00001
  - DIMM: 0001x
  - LOAD: 001xx
  - JUMP: 010xx
  - ALUI: 011xx
  - BRANCH: 10xxx
  - STORE: 110xx
  - ALUR: 111xx
- Control word, latched at the end of DECODE and held until the next DECODE:
  - alu_src = ALUI | LOAD | STORE
  - bh = op[1]
  - unsig = op[0]
  - alu_b = {op[2], op[1]}
  - alu_op[0] = LOAD | STORE | op == 11111 | op == 01111
  - alu_op[1] = BRANCH | op == 11111
  - imm_op = {JAL/RST/DIMM & op[0], JAL | JUMP | BRANCH, JAL/RST/DIMM, ALUI | LOAD}
- FETCH:
  - Asserts mem_req = 1, mem_we = 0, mem_data_sel = 0.
  - On mem_ack: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE:
  - Lasts 1 cycle.
  - If any upper opcode bit is nonzero, go to FAULT; otherwise go to EXEC.
- EXEC:
  - Lasts 1 cycle.
  - BRANCH: pc_write = br_cond, pc_src = 1, then retire and go to FETCH.
  - JUMP: pc_write = 1, pc_src = 2, then go to WB (link write).
  - JAL: pc_write = 1, pc_src = 2, then go to WB.
  - LOAD, STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - Asserts mem_req = 1, mem_data_sel = 1, mem_we = STORE.
  - On mem_ack: STORE retires and goes to FETCH; LOAD goes to WB.
- WB:
  - Lasts 1 cycle.
  - reg_write = 1.
  - mem_to_reg = LOAD.
  - reg_zero = RST.
  - Retires, then goes to FETCH.
- Retire: retired pulses for 1 cycle and retire_cnt increments, wrapping at 2^CNT_W to 0.
- Minimum latency with mem_ack in the first request cycle:
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - ALUI, ALUR, DIMM, RST, JUMP, JAL: 4 cycles
  - LOAD: 5 cycles
- Handshake:
  - mem_req, mem_we and mem_data_sel stay stable from assertion until the ack cycle inclusive.
  - mem_ack while mem_req = 0 is ignored.
- Watchdog:
  - The wait counter increments each cycle mem_req = 1 and mem_ack = 0, and clears on ack or on any state change.
  - When it reaches MEM_TIMEOUT, go to FAULT on the next edge.
  - mem_ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal completion, no fault.
- FAULT:
  - fault = 1; all strobes and mem_req = 0.
  - Held until rst; retire_cnt is frozen.
- Strobe exclusivity: only strobes listed for the current state are ever asserted; reg_write and mem_we are never high together.

Test Plan:
- ALUR op=11111, ack in first cycle: reset, fetch -> states 0,1,2,4,0. reg_write = 1 only in WB; alu_op = 11, alu_src = 0; retire_cnt = 1.
- LOAD op=00110, data ack delayed 3 cycles: mem_data_sel = 1 and mem_req held 4 cycles. WB shows mem_to_reg = 1, bh = 1. Total 8 cycles; imm_op = 0001.
- BRANCH op=10000, br_cond = 1 then 0: EXEC pc_write = 1, pc_src = 1 in the first run; pc_write = 0 in the second. Both retire in 3 cycles; imm_op = 0100, alu_op = 10.
- STORE op=11000, ack never arrives, MEM_TIMEOUT = 16: FAULT entered after 16 wait cycles; fault = 1 and all strobes 0 until rst; a rst pulse returns state to 0 with retire_cnt = 0.
- Upper opcode bit set with OPCODE_W = 6 (ir_opcode = 100001): DECODE -> FAULT; no reg_write. The same test with ir_opcode = 000001 (RST): WB reg_zero = 1, imm_op = 1010.
- CNT_W = 2, five ALUI instructions (op = 01111): retire_cnt sequence 1, 2, 3, 0, 1; retired pulses exactly 5 times.
